// File: rtl/counter_pkg.sv
// Shared types and encodings for the counter unit and its add/sub datapath.
package counter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_UP     = 1'b0;
  localparam logic OP_DOWN   = 1'b1;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

endpackage

// File: rtl/addsub_sat.sv
// Parametrised adder/subtractor with carry/borrow detection and optional clamping.
module addsub_sat
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STEP_W = 4
) (
  input  logic [WIDTH-1:0]  a,
  input  logic [STEP_W-1:0] b,
  input  logic              op,
  input  logic              mode,
  output logic [WIDTH-1:0]  result,
  output logic              carry,
  output logic              clamp
);

  localparam int unsigned RW = WIDTH + 1;

  logic [RW-1:0] r;

  // Extra top bit holds the carry out (up) or borrow (down).
  always_comb begin
    if (op == OP_UP) r = RW'(a) + RW'(b);
    else             r = RW'(a) - RW'(b);
  end

  assign carry  = r[WIDTH];
  assign clamp  = (mode == MODE_SAT) && r[WIDTH];
  assign result = clamp ? ((op == OP_DOWN) ? '0 : '1) : r[WIDTH-1:0];

endmodule

// File: rtl/counter_unit.sv
// Counter register, limit comparator and start/stop run controller around addsub_sat.
module counter_unit
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STEP_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              op,
  input  logic              mode,
  input  logic [STEP_W-1:0] step,
  input  logic [WIDTH-1:0]  limit,
  input  logic              c_ld,
  input  logic              c_clr,
  input  logic [WIDTH-1:0]  load_val,
  output logic [WIDTH-1:0]  c_out,
  output logic              z,
  output logic              m,
  output logic              busy,
  output logic              done,
  output logic              sat,
  output logic              wrap
);

  state_t state, state_n;

  logic [WIDTH-1:0]  c_q, c_n, limit_q, sum;
  logic [STEP_W-1:0] step_q;
  logic              op_q, mode_q;
  logic              sat_n, wrap_n, latch;
  logic              carry, clamp;

  addsub_sat #(
    .WIDTH  (WIDTH),
    .STEP_W (STEP_W)
  ) u_addsub (
    .a      (c_q),
    .b      (step_q),
    .op     (op_q),
    .mode   (mode_q),
    .result (sum),
    .carry  (carry),
    .clamp  (clamp)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next state and next counter/flag values; RUN checks stop, then limit, then updates.
  always_comb begin
    state_n = state;
    c_n     = c_q;
    sat_n   = sat;
    wrap_n  = 1'b0;
    latch   = 1'b0;
    unique case (state)
      IDLE: begin
        if (c_clr)     c_n = '0;
        else if (c_ld) c_n = load_val;
        if (start) begin
          latch   = 1'b1;
          sat_n   = 1'b0;
          state_n = RUN;
        end
      end
      RUN: begin
        if (stop) begin
          sat_n   = 1'b0;
          state_n = DONE;
        end else if (c_q == limit_q) begin
          state_n = DONE;
        end else begin
          c_n = sum;
          if (clamp) begin
            sat_n   = 1'b1;
            state_n = DONE;
          end else begin
            wrap_n = (mode_q == MODE_WRAP) && carry;
          end
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      c_q     <= '0;
      op_q    <= OP_UP;
      mode_q  <= MODE_WRAP;
      step_q  <= '0;
      limit_q <= '0;
      sat     <= 1'b0;
      wrap    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      c_q  <= c_n;
      sat  <= sat_n;
      wrap <= wrap_n;
      busy <= (state_n == RUN);
      done <= (state_n == DONE);
      if (latch) begin
        op_q    <= op;
        mode_q  <= mode;
        step_q  <= (step == '0) ? STEP_W'(1) : step;
        limit_q <= limit;
      end
    end
  end

  assign c_out = c_q;
  assign z     = (c_q == '0);
  assign m     = (c_q == '1);

endmodule

// File: tb/tb_counter_unit.sv
// Self-checking bench for counter_unit: table of runs with a scoreboard queue plus hand sequences.
module tb_counter_unit;

  localparam int unsigned W  = 8;
  localparam int unsigned SW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          op = 1'b0;
  logic          mode = 1'b0;
  logic [SW-1:0] step = '0;
  logic [W-1:0]  limit = '0;
  logic          c_ld = 1'b0;
  logic          c_clr = 1'b0;
  logic [W-1:0]  load_val = '0;
  logic [W-1:0]  c_out;
  logic          z, m, busy, done, sat, wrap;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [W-1:0]  init;
    logic          op;
    logic          mode;
    logic [SW-1:0] step;
    logic [W-1:0]  limit;
    logic [W-1:0]  exp_c;
    logic          exp_sat;
    int            exp_busy;
    int            exp_wrap;
  } vec_t;

  vec_t vecs[9];
  vec_t exp_q[$];

  counter_unit #(.WIDTH(W), .STEP_W(SW)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .stop     (stop),
    .op       (op),
    .mode     (mode),
    .step     (step),
    .limit    (limit),
    .c_ld     (c_ld),
    .c_clr    (c_clr),
    .load_val (load_val),
    .c_out    (c_out),
    .z        (z),
    .m        (m),
    .busy     (busy),
    .done     (done),
    .sat      (sat),
    .wrap     (wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Load the start value, launch a run, count busy/wrap cycles and score it at done.
  task automatic run_vec(input vec_t v, input int idx);
    int   nb;
    int   nw;
    bit   seen;
    vec_t e;
    @(negedge clk);
    c_ld = 1'b1; load_val = v.init;
    @(negedge clk);
    c_ld = 1'b0; start = 1'b1;
    op = v.op; mode = v.mode; step = v.step; limit = v.limit;
    exp_q.push_back(v);
    @(negedge clk);
    start = 1'b0;
    nb = 0; nw = 0; seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) nb++;
      if (wrap) nw++;
      @(negedge clk);
    end
    chk($sformatf("v%0d done_seen", idx), 32'(seen), 32'd1);
    if (wrap) nw++;
    e = exp_q.pop_front();
    chk($sformatf("v%0d c_out", idx), 32'(c_out), 32'(e.exp_c));
    chk($sformatf("v%0d sat", idx), 32'(sat), 32'(e.exp_sat));
    chk($sformatf("v%0d z", idx), 32'(z), 32'(e.exp_c == 0));
    chk($sformatf("v%0d m", idx), 32'(m), 32'(e.exp_c == 8'hFF));
    chk($sformatf("v%0d busy_at_done", idx), 32'(busy), 32'd0);
    chk($sformatf("v%0d busy_cycles", idx), 32'(nb), 32'(e.exp_busy));
    chk($sformatf("v%0d wrap_pulses", idx), 32'(nw), 32'(e.exp_wrap));
    @(negedge clk);
    chk($sformatf("v%0d done_pulse", idx), 32'(done), 32'd0);
    chk($sformatf("v%0d idle_busy", idx), 32'(busy), 32'd0);
  endtask

  initial begin
    //            init    op    mode  step   limit   exp_c  sat  busy wrap
    vecs[0] = '{8'd0,   1'b0, 1'b0, 4'd3,  8'd9,   8'd9,   1'b0, 4, 0};
    vecs[1] = '{8'd250, 1'b0, 1'b1, 4'd4,  8'd0,   8'd255, 1'b1, 2, 0};
    vecs[2] = '{8'd5,   1'b0, 1'b0, 4'd0,  8'd7,   8'd7,   1'b0, 3, 0};
    vecs[3] = '{8'd10,  1'b1, 1'b1, 4'd4,  8'd1,   8'd0,   1'b1, 3, 0};
    vecs[4] = '{8'd250, 1'b0, 1'b0, 4'd5,  8'd4,   8'd4,   1'b0, 3, 1};
    vecs[5] = '{8'd7,   1'b0, 1'b0, 4'd2,  8'd7,   8'd7,   1'b0, 1, 0};
    vecs[6] = '{8'd3,   1'b1, 1'b0, 4'd2,  8'd255, 8'd255, 1'b0, 3, 1};
    vecs[7] = '{8'd251, 1'b0, 1'b1, 4'd4,  8'd255, 8'd255, 1'b0, 2, 0};
    vecs[8] = '{8'd0,   1'b0, 1'b0, 4'd15, 8'd45,  8'd45,  1'b0, 4, 0};

    // Reset state
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst c_out", 32'(c_out), 32'd0);
    chk("rst z", 32'(z), 32'd1);
    chk("rst m", 32'(m), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst sat", 32'(sat), 32'd0);
    chk("rst wrap", 32'(wrap), 32'd0);

    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    // Wrap down with stop abort
    @(negedge clk);
    c_ld = 1'b1; load_val = 8'd2;
    @(negedge clk);
    c_ld = 1'b0; start = 1'b1; op = 1'b1; mode = 1'b0; step = 4'd3; limit = 8'd251;
    @(negedge clk);
    start = 1'b0;
    chk("wd c0", 32'(c_out), 32'd2);
    chk("wd busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("wd c1", 32'(c_out), 32'd255);
    chk("wd wrap1", 32'(wrap), 32'd1);
    @(negedge clk);
    chk("wd c2", 32'(c_out), 32'd252);
    chk("wd wrap2", 32'(wrap), 32'd0);
    @(negedge clk);
    chk("wd c3", 32'(c_out), 32'd249);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("wd done", 32'(done), 32'd1);
    chk("wd c_hold", 32'(c_out), 32'd249);
    chk("wd sat", 32'(sat), 32'd0);
    chk("wd busy_off", 32'(busy), 32'd0);

    // Control priority: clear beats load, load ignored in RUN, start ignored in DONE
    @(negedge clk);
    c_ld = 1'b1; c_clr = 1'b1; load_val = 8'd77;
    @(negedge clk);
    c_ld = 1'b0; c_clr = 1'b0;
    chk("pri clr", 32'(c_out), 32'd0);
    chk("pri z", 32'(z), 32'd1);
    start = 1'b1; op = 1'b0; mode = 1'b0; step = 4'd1; limit = 8'd200;
    @(negedge clk);
    start = 1'b0;
    chk("pri busy", 32'(busy), 32'd1);
    c_ld = 1'b1; load_val = 8'd99;
    @(negedge clk);
    c_ld = 1'b0;
    chk("pri ld_ignored", 32'(c_out), 32'd1);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("pri done", 32'(done), 32'd1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("pri start_in_done busy", 32'(busy), 32'd0);
    chk("pri start_in_done done", 32'(done), 32'd0);
    @(negedge clk);
    chk("pri still_idle", 32'(busy), 32'd0);
    chk("pri c_after", 32'(c_out), 32'd1);

    // Clear in the start cycle is applied before the run begins
    c_clr = 1'b1; start = 1'b1; op = 1'b0; mode = 1'b0; step = 4'd1; limit = 8'd0;
    @(negedge clk);
    c_clr = 1'b0; start = 1'b0;
    chk("clrstart c", 32'(c_out), 32'd0);
    chk("clrstart busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("clrstart done", 32'(done), 32'd1);
    chk("clrstart c_done", 32'(c_out), 32'd0);

    // Reset in the second RUN cycle, just after a wrapping update
    @(negedge clk);
    c_ld = 1'b1; load_val = 8'd254;
    @(negedge clk);
    c_ld = 1'b0; start = 1'b1; op = 1'b0; mode = 1'b0; step = 4'd2; limit = 8'd100;
    @(negedge clk);
    start = 1'b0;
    chk("mr busy1", 32'(busy), 32'd1);
    @(negedge clk);
    chk("mr c_before", 32'(c_out), 32'd0);
    chk("mr wrap_before", 32'(wrap), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mr c", 32'(c_out), 32'd0);
    chk("mr z", 32'(z), 32'd1);
    chk("mr m", 32'(m), 32'd0);
    chk("mr busy", 32'(busy), 32'd0);
    chk("mr done", 32'(done), 32'd0);
    chk("mr sat", 32'(sat), 32'd0);
    chk("mr wrap", 32'(wrap), 32'd0);
    @(negedge clk);
    chk("mr stays_idle", 32'(busy), 32'd0);

    run_vec(vecs[0], 100);
    run_vec(vecs[1], 101);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
